mmio_port_unit: RTL
===================

# mmio_port_unit

Memory-mapped I/O responder on the single-cycle processor's data-memory bus, in parallel with DataMemory. It owns the 32-bit PortOut register and a synchronized, change-flagged view of the 8-bit PortIn. It also runs a small transmit FIFO that drains bytes to an external consumer over a valid/ready handshake. The top level muxes ReadData onto the load path whenever Hit is high.

## Interface
- BASE_ADDRESS, 32'h1001_0040, 16-byte-aligned base of the register window
- FIFO_DEPTH, 4, TX FIFO entries; power of two, ≥2
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- Address  in  32  processor ALU result (byte address)
- WriteData  in  32  store data (ReadData2)
- MemWrite  in  1  store strobe from Control
- MemRead  in  1  load strobe from Control
- ReadData  out  32  combinational register read data
- Hit  out  1  combinational: Address[31:4] == BASE_ADDRESS[31:4]
- PortIn  in  8  asynchronous external input
- PortOut  out  32  PORT_OUT register
- TxData  out  8  FIFO head byte
- TxValid  out  1  FIFO non-empty
- TxReady  in  1  consumer accepts head when TxValid & TxReady

## Operation
- Decode: offset = Address[3:2]; Address[1:0] ignored. Accesses with Hit=0 have no effect, and ReadData=0.
- Offset 0, PORT_OUT (RW): a store loads all 32 bits. A load returns the register.
- Offset 1, PORT_IN (RO): returns {24'b0, in_sync}. A load clears the CHANGE flag.
- Offset 2, STATUS (RO): bit0 CHANGE, bit1 FULL, bit2 EMPTY, bit3 OVERFLOW, bits[7:4] count, rest 0. A load clears OVERFLOW.
- Offset 3, TX_DATA (WO): a store pushes WriteData[7:0]. A load returns 0.
- Stores to RO offsets and loads from WO offsets are ignored, with no side effects.
- Input path: PortIn → sync1 → in_sync (2 flops) → in_prev (1 flop). CHANGE is set when in_sync != in_prev.
- CHANGE set and clear in the same cycle: set wins.
- Push while full, with no pop that cycle: the data is dropped and OVERFLOW is set. OVERFLOW set and STATUS-load clear in the same cycle: set wins.
- Push while full with a pop that same cycle: the pop occurs and the push is accepted; count stays at FIFO_DEPTH.
- Push while empty: there is no pop that cycle, since TxValid=0 when the cycle starts.
- Push and pop in the same cycle, not full: count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits, zero-extended into STATUS[7:4].
- A load and a store in the same cycle cannot occur; if it does, the store takes effect and the read side effects still apply.

## Timing
- Reset values: PortOut=0, sync1/in_sync/in_prev=0, CHANGE=0, OVERFLOW=0, FIFO empty (TxValid=0, TxData=0), count=0.
- ReadData and Hit are combinational from Address and current state, matching the single-cycle load path.
- All writes and read side effects commit on the rising clk edge that ends the instruction cycle.
- PORT_OUT store: PortOut updates one edge after the store cycle.
- PortIn step change becomes visible in PORT_IN after 2 edges. CHANGE is readable after 3 edges and drops back to 0 the cycle after the clear, unless it is re-set.
- TX push: TxValid rises the edge after an empty-FIFO push. TxData is the registered head (FIFO array output); it is stable while TxValid=1 and TxReady=0.
- Reset mid-transfer: the FIFO is flushed and TxValid drops the next edge regardless of TxReady.

## Structure
- Package mmio_port_pkg: offset constants (OFS_PORT_OUT=2'd0, OFS_PORT_IN=2'd1, OFS_STATUS=2'd2, OFS_TX_DATA=2'd3), STATUS bit-index constants, default BASE_ADDRESS.
- Sub-module sync_fifo (params WIDTH=8, DEPTH): push/pop/full/empty/count, full-with-pop push acceptance. Decode, registers, synchronizer and flags stay in mmio_port_unit.

## Test plan
- Reset, then store 0xDEADBEEF to BASE+0 → PortOut=0xDEADBEEF next edge. A load from BASE+0 returns 0xDEADBEEF with Hit=1. Same store to BASE+0x10 → Hit=0, PortOut unchanged.
- PortIn 0x00→0xA5 → PORT_IN reads 0xA5 after 2 edges and STATUS bit0=1 after 3. A load from PORT_IN → STATUS bit0=0 next cycle. Holding PortIn with a reload keeps it 0.
- TxReady=0; push 0x11,0x22,0x33,0x44 → STATUS=0x42 (count 4, FULL). A fifth push of 0x55 → STATUS=0x4A. A STATUS load → OVERFLOW clears, and a later TxReady=1 drains 0x11..0x44 in order with 0x55 absent.
- FIFO full, TxReady=1, push 0x66 in the same cycle → 0x11 pops and 0x66 is accepted, count stays 4, OVERFLOW=0.
- Empty FIFO, TxReady held 1: push 0x77 → TxValid high for exactly one cycle with TxData=0x77. STATUS returns to 0x04 (EMPTY).
- FIFO holding 2 bytes and PortOut nonzero, assert reset for one cycle → all outputs at reset values on the next edge, TxValid=0.

Source files
------------

// File: rtl/mmio_port_pkg.sv
// Purpose : shared constants and types for the MMIO port unit (register offsets, STATUS layout).
// Latency : n/a (declarations only).
// Backpressure: n/a.
package mmio_port_pkg;

    // Default 16-byte-aligned base of the four-register window
    localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h1001_0040;

    // Word offsets within the window (Address[3:2])
    localparam logic [1:0] OFS_PORT_OUT = 2'd0;
    localparam logic [1:0] OFS_PORT_IN  = 2'd1;
    localparam logic [1:0] OFS_STATUS   = 2'd2;
    localparam logic [1:0] OFS_TX_DATA  = 2'd3;

    // STATUS bit positions
    localparam int STAT_CHANGE   = 0;
    localparam int STAT_FULL     = 1;
    localparam int STAT_EMPTY    = 2;
    localparam int STAT_OVERFLOW = 3;
    localparam int STAT_CNT_LSB  = 4;
    localparam int STAT_CNT_W    = 4;

    // STATUS register image, MSB first; field order mirrors the bit constants above
    typedef struct packed {
        logic [23:0] rsvd;
        logic [3:0]  count;
        logic        overflow;
        logic        empty;
        logic        full;
        logic        change;
    } status_t;

endpackage

// File: rtl/mmio_port_unit_if.sv
// Purpose : data-memory bus slice seen by the MMIO unit plus its byte transmit stream.
// Latency : n/a (wires only).
// Backpressure: TxReady from the consumer holds the transmit head while low.
interface mmio_port_unit_if;

    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Hit;
    logic [7:0]  TxData;
    logic        TxValid;
    logic        TxReady;

    // Processor side drives the bus and acts as the stream consumer
    modport master (
        output Address, WriteData, MemWrite, MemRead, TxReady,
        input  ReadData, Hit, TxData, TxValid
    );

    // MMIO unit side
    modport slave (
        input  Address, WriteData, MemWrite, MemRead, TxReady,
        output ReadData, Hit, TxData, TxValid
    );

endinterface

// File: rtl/mmio_port_unit_sync_fifo.sv
// Purpose : small synchronous FIFO with registered-array head output and drop indication.
// Latency : push visible at head one edge later; pop advances head on the same edge.
// Backpressure: push while full is accepted only when a pop happens that cycle, else dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             pushData,
    input  logic                         pop,
    output logic [WIDTH-1:0]             popData,
    output logic                         full,
    output logic                         empty,
    output logic                         dropped,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             pushOk;
    logic             popOk;

    // Accept/drop decisions; a full FIFO frees its head slot when popping, so the push fits
    always_comb begin
        popOk   = pop && !empty;
        pushOk  = push && (!full || popOk);
        dropped = push && full && !popOk;
    end

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign popData = mem[rdPtr];

    // Storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (popOk) begin
                rdPtr <= rdPtr + 1'b1;
            end
            count <= count + CNT_W'(pushOk) - CNT_W'(popOk);
        end
    end

endmodule

// File: rtl/mmio_port_unit.sv
// Purpose : MMIO responder beside DataMemory: PortOut register, synchronized PortIn, STATUS, TX FIFO.
// Latency : reads combinational; writes/read side effects commit on the ending edge; PortIn visible after 2 edges.
// Backpressure: TX head held while TxReady low; stores to a full FIFO without a pop are dropped and flag OVERFLOW.
module mmio_port_unit
    import mmio_port_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    mmio_port_unit_if.slave   bus,
    input  logic [7:0]        PortIn,
    output logic [31:0]       PortOut
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       offset;
    logic             wrEn;
    logic             rdEn;
    logic [7:0]       sync1;
    logic [7:0]       inSync;
    logic [7:0]       inPrev;
    logic             change;
    logic             overflow;
    logic             txPush;
    logic             txFull;
    logic             txEmpty;
    logic             txDropped;
    logic [CNT_W-1:0] txCount;
    status_t          status;

    // Address decode; only the upper 28 bits select the window, byte lane bits are ignored
    always_comb begin
        bus.Hit = (bus.Address[31:4] == BASE_ADDRESS[31:4]);
        offset  = bus.Address[3:2];
        wrEn    = bus.MemWrite && bus.Hit;
        rdEn    = bus.MemRead && bus.Hit;
        txPush  = wrEn && (offset == OFS_TX_DATA);
    end

    // STATUS image assembled from live flags and FIFO occupancy
    always_comb begin
        status          = '0;
        status.change   = change;
        status.full     = txFull;
        status.empty    = txEmpty;
        status.overflow = overflow;
        status.count    = STAT_CNT_W'(txCount);
    end

    // Combinational load data for the single-cycle load path; zero outside the window
    always_comb begin
        bus.ReadData = '0;
        if (bus.Hit) begin
            case (offset)
                OFS_PORT_OUT: bus.ReadData = PortOut;
                OFS_PORT_IN:  bus.ReadData = {24'b0, inSync};
                OFS_STATUS:   bus.ReadData = status;
                default:      bus.ReadData = '0;
            endcase
        end
    end

    // PORT_OUT register: full-word store
    always_ff @(posedge clk) begin
        if (reset) begin
            PortOut <= '0;
        end else if (wrEn && (offset == OFS_PORT_OUT)) begin
            PortOut <= bus.WriteData;
        end
    end

    // Two-flop synchronizer plus a history flop for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            inSync <= '0;
            inPrev <= '0;
        end else begin
            sync1  <= PortIn;
            inSync <= sync1;
            inPrev <= inSync;
        end
    end

    // CHANGE flag: a fresh difference outranks a PORT_IN load clearing it
    always_ff @(posedge clk) begin
        if (reset) begin
            change <= 1'b0;
        end else if (inSync != inPrev) begin
            change <= 1'b1;
        end else if (rdEn && (offset == OFS_PORT_IN)) begin
            change <= 1'b0;
        end
    end

    // OVERFLOW flag: a dropped push outranks a STATUS load clearing it
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (txDropped) begin
            overflow <= 1'b1;
        end else if (rdEn && (offset == OFS_STATUS)) begin
            overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_txFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (txPush),
        .pushData (bus.WriteData[7:0]),
        .pop      (bus.TxReady),
        .popData  (bus.TxData),
        .full     (txFull),
        .empty    (txEmpty),
        .dropped  (txDropped),
        .count    (txCount)
    );

    assign bus.TxValid = !txEmpty;

endmodule
